// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported 64-bit memory between fetch and load/store.
// Optional fetch starvation guard is enabled by defining FETCH_STARVE_GUARD_EN.
module unified_mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 15
`ifdef FETCH_STARVE_GUARD_EN
   , parameter int MAX_D_STREAK = 4
`endif
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_rdata_o,
   output logic              if_ready_o,
   input  logic              d_rd_i,
   input  logic              d_wr_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [63:0]       d_wdata_i,
   output logic [63:0]       d_rdata_o,
   output logic              d_ready_o,
   output logic              stall_if_o,
   output logic              stall_mem_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [63:0]       mem_wdata_o,
   input  logic [63:0]       mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              err_o
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;
   localparam int CW = $clog2(TIMEOUT + 1);
   state_e            state_q, state_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [63:0]       mem_wdata_q, mem_wdata_d;
   logic [CW-1:0]     tcnt_q, tcnt_d;
   logic              live_q, live_d;
   logic              err_q, err_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [63:0]       d_rdata_q, d_rdata_d;
   logic              d_req, starve, gnt_i, gnt_d, done;
   logic [63:0]       rdata;
   assign d_req = d_rd_i | d_wr_i;
   assign gnt_i = (state_q == IDLE) & if_req_i & (~d_req | starve);
   assign gnt_d = (state_q == IDLE) & d_req & ~gnt_i;
   assign done  = mem_ack_i | (tcnt_q == CW'(TIMEOUT - 1));
   assign rdata = mem_ack_i ? mem_rdata_i : '0;
`ifdef FETCH_STARVE_GUARD_EN
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   logic [SW-1:0] streak_q, streak_d;
   assign starve   = streak_q == SW'(MAX_D_STREAK);
   assign streak_d = gnt_i ? '0 : (gnt_d & if_req_i) ? streak_q + SW'(1) : streak_q;
   // count data grants that overtook a waiting fetch
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) streak_q <= '0;
      else         streak_q <= streak_d;
   end
`else
   assign starve = 1'b0;
`endif
   // grant FSM next state plus transaction/response register updates
   always_comb begin
      state_d     = state_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tcnt_d      = tcnt_q;
      live_d      = live_q;
      err_d       = 1'b0;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_i) begin
               state_d    = BUSY_I;
               mem_en_d   = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr_i;
               tcnt_d     = '0;
               live_d     = 1'b1;
            end else if (gnt_d) begin
               state_d     = BUSY_D;
               mem_en_d    = 1'b1;
               mem_we_d    = d_wr_i;
               mem_addr_d  = d_addr_i;
               mem_wdata_d = d_wdata_i;
               tcnt_d      = '0;
               live_d      = 1'b1;
               err_d       = d_rd_i & d_wr_i;
            end
         end
         BUSY_I, BUSY_D: begin
            live_d = live_q & (state_q == BUSY_I ? if_req_i : d_req);
            tcnt_d = tcnt_q + CW'(1);
            if (done) begin
               state_d = RESP;
               err_d   = ~mem_ack_i;
               if (state_q == BUSY_I && live_d) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_addr_q[2] ? rdata[63:32] : rdata[31:0];
               end
               if (state_q == BUSY_D && live_d) begin
                  d_ready_d = 1'b1;
                  d_rdata_d = mem_we_q ? d_rdata_q : rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, all cleared by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tcnt_q      <= '0;
         live_q      <= 1'b0;
         err_q       <= 1'b0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tcnt_q      <= tcnt_d;
         live_q      <= live_d;
         err_q       <= err_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end
   assign if_rdata_o  = if_rdata_q;
   assign if_ready_o  = if_ready_q;
   assign d_rdata_o   = d_rdata_q;
   assign d_ready_o   = d_ready_q;
   assign stall_if_o  = if_req_i & ~if_ready_q;
   assign stall_mem_o = d_req & ~d_ready_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign err_o       = err_q;
endmodule
